// File: rtl/wind_pulse_counter.sv
// Anemometer front end: synchronise and debounce the rotation contact, count rising
// edges per gate window, convert the count to BCD and hand it out with valid/ack.
module wind_pulse_counter #(
    parameter int GATE_CYCLES     = 50000000,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int MAX_COUNT       = 9999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rotation,
    input  logic        sample_ack,
    output logic [13:0] speed_bin,
    output logic [15:0] speed_bcd,
    output logic        sample_valid,
    output logic        overflow,
    output logic        sample_lost
);

    localparam int TW = $clog2(GATE_CYCLES);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [TW-1:0] GATE_LAST = TW'(GATE_CYCLES - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [13:0]   COUNT_MAX = 14'(MAX_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        DONE
    } state_t;

    // Front end: synchroniser, debouncer, gate timer, edge counter, capture register
    logic          sync1_q, sync2_q;
    logic          deb_q, deb_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [13:0]   count_q, count_d, count_inc;
    logic          ovf_q, ovf_d, ovf_inc;
    logic [13:0]   cap_bin_q, cap_bin_d;
    logic          cap_ovf_q, cap_ovf_d;
    logic          cap_pulse_q, cap_pulse_d;
    logic          deb_rise;
    logic          terminal;

    // Conversion engine and result registers
    state_t        state_q, state_d;
    logic [13:0]   shift_q, shift_d;
    logic [15:0]   bcd_q, bcd_d;
    logic [15:0]   bcd_adj;
    logic [3:0]    iter_q, iter_d;
    logic [13:0]   speed_bin_q, speed_bin_d;
    logic [15:0]   speed_bcd_q, speed_bcd_d;
    logic          valid_q, valid_d;
    logic          ovf_out_q, ovf_out_d;
    logic          lost_q, lost_d;

    // Double-dabble correction: any BCD digit >= 5 gets +3 before the shift.
    function automatic logic [15:0] dabble_adjust(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_d = ~deb_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
        deb_rise = deb_d & ~deb_q;

        count_inc = count_q;
        ovf_inc   = ovf_q;
        if (deb_rise) begin
            if (count_q >= COUNT_MAX) begin
                ovf_inc = 1'b1;
            end else begin
                count_inc = count_q + 14'd1;
            end
        end

        // The terminal cycle's own edge belongs to the closing window.
        terminal    = (timer_q == GATE_LAST);
        timer_d     = terminal ? '0 : timer_q + 1'b1;
        count_d     = terminal ? 14'd0 : count_inc;
        ovf_d       = terminal ? 1'b0 : ovf_inc;
        cap_bin_d   = terminal ? count_inc : cap_bin_q;
        cap_ovf_d   = terminal ? ovf_inc : cap_ovf_q;
        cap_pulse_d = terminal;
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bcd_d       = bcd_q;
        bcd_adj     = dabble_adjust(bcd_q);
        iter_d      = iter_q;
        speed_bin_d = speed_bin_q;
        speed_bcd_d = speed_bcd_q;
        ovf_out_d   = ovf_out_q;
        valid_d     = valid_q;
        lost_d      = lost_q;

        if (sample_ack && valid_q) begin
            valid_d = 1'b0;
            lost_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (cap_pulse_q) begin
                    shift_d = cap_bin_q;
                    bcd_d   = 16'd0;
                    iter_d  = 4'd0;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                bcd_d   = {bcd_adj[14:0], shift_q[13]};
                shift_d = {shift_q[12:0], 1'b0};
                iter_d  = iter_q + 4'd1;
                if (iter_q == 4'd13) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                speed_bin_d = cap_bin_q;
                speed_bcd_d = bcd_q;
                ovf_out_d   = cap_ovf_q;
                valid_d     = 1'b1;
                // A same-cycle ack retires the old result, so nothing is lost.
                if (valid_q && !sample_ack) begin
                    lost_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            deb_q       <= 1'b0;
            deb_cnt_q   <= '0;
            timer_q     <= '0;
            count_q     <= 14'd0;
            ovf_q       <= 1'b0;
            cap_bin_q   <= 14'd0;
            cap_ovf_q   <= 1'b0;
            cap_pulse_q <= 1'b0;
            state_q     <= IDLE;
            shift_q     <= 14'd0;
            bcd_q       <= 16'd0;
            iter_q      <= 4'd0;
            speed_bin_q <= 14'd0;
            speed_bcd_q <= 16'd0;
            ovf_out_q   <= 1'b0;
            valid_q     <= 1'b0;
            lost_q      <= 1'b0;
        end else begin
            sync1_q     <= rotation;
            sync2_q     <= sync1_q;
            deb_q       <= deb_d;
            deb_cnt_q   <= deb_cnt_d;
            timer_q     <= timer_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            cap_bin_q   <= cap_bin_d;
            cap_ovf_q   <= cap_ovf_d;
            cap_pulse_q <= cap_pulse_d;
            state_q     <= state_d;
            shift_q     <= shift_d;
            bcd_q       <= bcd_d;
            iter_q      <= iter_d;
            speed_bin_q <= speed_bin_d;
            speed_bcd_q <= speed_bcd_d;
            ovf_out_q   <= ovf_out_d;
            valid_q     <= valid_d;
            lost_q      <= lost_d;
        end
    end

    assign speed_bin    = speed_bin_q;
    assign speed_bcd    = speed_bcd_q;
    assign sample_valid = valid_q;
    assign overflow     = ovf_out_q;
    assign sample_lost  = lost_q;

endmodule

// File: tb/tb_wind_pulse_counter.sv
// Directed bench for wind_pulse_counter: three instances share stimulus; each test
// resets, drives pulses on an absolute cycle schedule and checks one instance.
module tb_wind_pulse_counter;

    typedef logic [32:0] obs_t;  // {valid, lost, ovf, bin[13:0], bcd[15:0]}

    logic clk = 1'b0;
    logic reset, rotation, sample_ack;

    logic [13:0] bin_a, bin_b, bin_c;
    logic [15:0] bcd_a, bcd_b, bcd_c;
    logic        valid_a, valid_b, valid_c;
    logic        ovf_a, ovf_b, ovf_c;
    logic        lost_a, lost_b, lost_c;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    wind_pulse_counter #(.GATE_CYCLES(100), .DEBOUNCE_CYCLES(4), .MAX_COUNT(9999)) dut_a (
        .clk(clk), .reset(reset), .rotation(rotation), .sample_ack(sample_ack),
        .speed_bin(bin_a), .speed_bcd(bcd_a), .sample_valid(valid_a),
        .overflow(ovf_a), .sample_lost(lost_a));

    wind_pulse_counter #(.GATE_CYCLES(100), .DEBOUNCE_CYCLES(4), .MAX_COUNT(5)) dut_b (
        .clk(clk), .reset(reset), .rotation(rotation), .sample_ack(sample_ack),
        .speed_bin(bin_b), .speed_bcd(bcd_b), .sample_valid(valid_b),
        .overflow(ovf_b), .sample_lost(lost_b));

    // Window shortened from 100000 to 20000 cycles; 4321 pulses of 4 cycles still fit.
    wind_pulse_counter #(.GATE_CYCLES(20000), .DEBOUNCE_CYCLES(2), .MAX_COUNT(9999)) dut_c (
        .clk(clk), .reset(reset), .rotation(rotation), .sample_ack(sample_ack),
        .speed_bin(bin_c), .speed_bcd(bcd_c), .sample_valid(valid_c),
        .overflow(ovf_c), .sample_lost(lost_c));

    function automatic obs_t pack(input logic v, input logic l, input logic o,
                                  input logic [13:0] b, input logic [15:0] d);
        return {v, l, o, b, d};
    endfunction

    function automatic string show(input obs_t x);
        return $sformatf("valid=%0b lost=%0b ovf=%0b bin=%0d bcd=%h",
                         x[32], x[31], x[30], x[29:16], x[15:0]);
    endfunction

    function automatic obs_t obs_a();
        return pack(valid_a, lost_a, ovf_a, bin_a, bcd_a);
    endfunction

    function automatic obs_t obs_b();
        return pack(valid_b, lost_b, ovf_b, bin_b, bcd_b);
    endfunction

    function automatic obs_t obs_c();
        return pack(valid_c, lost_c, ovf_c, bin_c, bcd_c);
    endfunction

    // cyc counts negedges since reset release; negedge k follows the k-th rising edge.
    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic goto(input int t);
        while (cyc < t) step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        rotation   = 1'b0;
        sample_ack = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic pulse_train(input int start, input int n, input int period, input int hi);
        for (int i = 0; i < n; i++) begin
            goto(start + i * period);
            rotation = 1'b1;
            goto(start + i * period + hi);
            rotation = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (obs_a() !== pack(0, 0, 0, 14'd0, 16'h0000)) begin
            errors++;
            $display("FAIL reset_a got %s want all zero", show(obs_a()));
        end
        checks++;
        if (obs_b() !== pack(0, 0, 0, 14'd0, 16'h0000)) begin
            errors++;
            $display("FAIL reset_b got %s want all zero", show(obs_b()));
        end
        checks++;
        if (obs_c() !== pack(0, 0, 0, 14'd0, 16'h0000)) begin
            errors++;
            $display("FAIL reset_c got %s want all zero", show(obs_c()));
        end
    endtask

    // Capture edge is rising edge 100; the result must appear on edge 116, not before.
    task automatic test_clean_pulses();
        do_reset();
        pulse_train(2, 7, 12, 6);
        goto(115);
        checks++;
        if (valid_a !== 1'b0) begin
            errors++;
            $display("FAIL clean_early_valid got %0b want 0", valid_a);
        end
        step();
        checks++;
        if (obs_a() !== pack(1, 0, 0, 14'd7, 16'h0007)) begin
            errors++;
            $display("FAIL clean_result got %s want %s", show(obs_a()), show(pack(1, 0, 0, 14'd7, 16'h0007)));
        end
    endtask

    task automatic test_glitch();
        do_reset();
        goto(2);
        rotation = 1'b1;
        goto(5);
        rotation = 1'b0;
        pulse_train(20, 2, 12, 6);
        goto(116);
        checks++;
        if (obs_a() !== pack(1, 0, 0, 14'd2, 16'h0002)) begin
            errors++;
            $display("FAIL glitch_result got %s want %s", show(obs_a()), show(pack(1, 0, 0, 14'd2, 16'h0002)));
        end
    endtask

    task automatic test_saturation();
        do_reset();
        pulse_train(2, 8, 12, 6);
        goto(116);
        checks++;
        if (obs_b() !== pack(1, 0, 1, 14'd5, 16'h0005)) begin
            errors++;
            $display("FAIL sat_result got %s want %s", show(obs_b()), show(pack(1, 0, 1, 14'd5, 16'h0005)));
        end
        goto(117);
        sample_ack = 1'b1;
        step();
        sample_ack = 1'b0;
        checks++;
        if (obs_b() !== pack(0, 0, 1, 14'd5, 16'h0005)) begin
            errors++;
            $display("FAIL sat_ack got %s want %s", show(obs_b()), show(pack(0, 0, 1, 14'd5, 16'h0005)));
        end
        pulse_train(120, 3, 12, 6);
        goto(216);
        checks++;
        if (obs_b() !== pack(1, 0, 0, 14'd3, 16'h0003)) begin
            errors++;
            $display("FAIL sat_next_window got %s want %s", show(obs_b()), show(pack(1, 0, 0, 14'd3, 16'h0003)));
        end
    endtask

    task automatic test_conversion();
        do_reset();
        pulse_train(2, 4321, 4, 2);
        goto(20016);
        checks++;
        if (obs_c() !== pack(1, 0, 0, 14'd4321, 16'h4321)) begin
            errors++;
            $display("FAIL conv_4321 got %s want %s", show(obs_c()), show(pack(1, 0, 0, 14'd4321, 16'h4321)));
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        pulse_train(2, 4, 12, 6);
        goto(116);
        checks++;
        if (obs_a() !== pack(1, 0, 0, 14'd4, 16'h0004)) begin
            errors++;
            $display("FAIL b2b_first got %s want %s", show(obs_a()), show(pack(1, 0, 0, 14'd4, 16'h0004)));
        end
        pulse_train(120, 6, 12, 6);
        goto(216);
        checks++;
        if (obs_a() !== pack(1, 1, 0, 14'd6, 16'h0006)) begin
            errors++;
            $display("FAIL b2b_lost got %s want %s", show(obs_a()), show(pack(1, 1, 0, 14'd6, 16'h0006)));
        end
        sample_ack = 1'b1;
        step();
        sample_ack = 1'b0;
        checks++;
        if (obs_a() !== pack(0, 0, 0, 14'd6, 16'h0006)) begin
            errors++;
            $display("FAIL b2b_ack got %s want %s", show(obs_a()), show(pack(0, 0, 0, 14'd6, 16'h0006)));
        end
        pulse_train(230, 1, 12, 6);
        goto(316);
        checks++;
        if (obs_a() !== pack(1, 0, 0, 14'd1, 16'h0001)) begin
            errors++;
            $display("FAIL b2b_third got %s want %s", show(obs_a()), show(pack(1, 0, 0, 14'd1, 16'h0001)));
        end
        // Ack lands exactly in the DONE cycle of the next window.
        pulse_train(320, 2, 12, 6);
        goto(415);
        sample_ack = 1'b1;
        step();
        sample_ack = 1'b0;
        checks++;
        if (obs_a() !== pack(1, 0, 0, 14'd2, 16'h0002)) begin
            errors++;
            $display("FAIL b2b_ack_in_done got %s want %s", show(obs_a()), show(pack(1, 0, 0, 14'd2, 16'h0002)));
        end
    endtask

    task automatic test_terminal_edge();
        do_reset();
        pulse_train(2, 2, 12, 6);
        pulse_train(94, 1, 12, 6);
        goto(116);
        checks++;
        if (obs_a() !== pack(1, 0, 0, 14'd3, 16'h0003)) begin
            errors++;
            $display("FAIL term_closing got %s want %s", show(obs_a()), show(pack(1, 0, 0, 14'd3, 16'h0003)));
        end
        sample_ack = 1'b1;
        step();
        sample_ack = 1'b0;
        goto(216);
        checks++;
        if (obs_a() !== pack(1, 0, 0, 14'd0, 16'h0000)) begin
            errors++;
            $display("FAIL term_next_zero got %s want %s", show(obs_a()), show(pack(1, 0, 0, 14'd0, 16'h0000)));
        end
    endtask

    task automatic test_reset_mid_convert();
        logic seen_valid;
        do_reset();
        pulse_train(2, 2, 12, 6);
        goto(116);
        checks++;
        if (obs_a() !== pack(1, 0, 0, 14'd2, 16'h0002)) begin
            errors++;
            $display("FAIL midrst_before got %s want %s", show(obs_a()), show(pack(1, 0, 0, 14'd2, 16'h0002)));
        end
        pulse_train(120, 3, 12, 6);
        goto(205);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (obs_a() !== pack(0, 0, 0, 14'd0, 16'h0000)) begin
            errors++;
            $display("FAIL midrst_zero got %s want all zero", show(obs_a()));
        end
        seen_valid = 1'b0;
        while (cyc < 240) begin
            step();
            if (valid_a === 1'b1) seen_valid = 1'b1;
        end
        checks++;
        if (seen_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_no_valid got valid=1 after abort want 0");
        end
    endtask

    initial begin
        reset      = 1'b1;
        rotation   = 1'b0;
        sample_ack = 1'b0;
        test_reset();
        test_clean_pulses();
        test_glitch();
        test_saturation();
        test_conversion();
        test_back_to_back();
        test_terminal_edge();
        test_reset_mid_convert();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
